// File: rtl/avalon_st_pkg.sv
// Shared types for the Avalon-ST skid stage: buffer state and the beat record.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// BEAT_BYTES sizes the beat struct. Any module that stores beats must be
// parameterised with a matching DATA_WIDTH_IN_BYTES.
package avalon_st_pkg;

    localparam int BEAT_BYTES = 16;
    localparam int EMPTY_W    = (BEAT_BYTES > 1) ? $clog2(BEAT_BYTES) : 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [BEAT_BYTES*8-1:0] data;
        logic                    sop;
        logic                    eop;
        logic [EMPTY_W-1:0]      empty;
    } avalon_st_beat_t;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle: payload, framing, byte-empty count, valid/rdy handshake.
// Latency: n/a (wiring only).
// Backpressure: the master holds a beat while rdy from the slave is low.
//
// master: drives data/sop/eop/empty/valid and samples rdy.
// slave : samples data/sop/eop/empty/valid and drives rdy.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic                             sop;
    logic                             eop;
    logic [EW-1:0]                    empty;
    logic                             valid;
    logic                             rdy;

    modport master (output data, output sop, output eop, output empty, output valid, input rdy);
    modport slave  (input data, input sop, input eop, input empty, input valid, output rdy);

endinterface

// File: rtl/avalon_st_protocol_checker.sv
// Packet framing checker: tracks in_packet and raises a sticky protocol_err.
// Latency: protocol_err rises the cycle after the offending accepted beat.
// Backpressure: none; purely observes accepted beats.
//
// Ports: clk, rst (async active-low), beat_accept (beat taken this cycle),
//        sop/eop of that beat, clear_stats (sync clear of the flag),
//        protocol_err (sticky output).
module avalon_st_protocol_checker (
    input  logic clk,
    input  logic rst,
    input  logic beat_accept,
    input  logic sop,
    input  logic eop,
    input  logic clear_stats,
    output logic protocol_err
);

    logic in_packet;
    logic violation;

    // A sop inside a packet, or a non-sop beat outside one, is a framing error.
    assign violation = beat_accept && ((sop && in_packet) || (!sop && !in_packet));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_packet    <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            // eop always closes the packet, so sop&&eop leaves in_packet clear.
            if (beat_accept) begin
                if (eop) begin
                    in_packet <= 1'b0;
                end else if (sop) begin
                    in_packet <= 1'b1;
                end
            end

            // clear_stats wins over a same-cycle violation; it does not touch in_packet.
            if (clear_stats) begin
                protocol_err <= 1'b0;
            end else if (violation) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/avalon_st_skid_stage.sv
// Two-entry registered skid buffer on an Avalon-ST stream, with packet counter and framing check.
// Latency: 1 cycle from input accept to msg_out.valid when empty; 1 beat/cycle sustained.
// Backpressure: msg_in.rdy = !FULL from registered state only; no comb path from msg_out.rdy.
//
// Ports: clk, rst (async active-low), msg_in (slave stream), msg_out (master stream),
//        clear_stats (sync clear of pkt_count/protocol_err),
//        pkt_count (eop beats sent, saturating), protocol_err (sticky framing flag).
module avalon_st_skid_stage
    import avalon_st_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = BEAT_BYTES,
    parameter int COUNT_WIDTH         = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    avalon_st_if.slave             msg_in,
    avalon_st_if.master            msg_out,
    input  logic                   clear_stats,
    output logic [COUNT_WIDTH-1:0] pkt_count,
    output logic                   protocol_err
);

    skid_state_t     state;
    avalon_st_beat_t main_q;
    avalon_st_beat_t skid_q;
    avalon_st_beat_t in_beat;
    logic            in_accept;
    logic            out_accept;

    assign in_beat.data  = msg_in.data[DATA_WIDTH_IN_BYTES*8-1:0];
    assign in_beat.sop   = msg_in.sop;
    assign in_beat.eop   = msg_in.eop;
    assign in_beat.empty = msg_in.empty;

    // Both handshake terms decode only from the state register.
    assign msg_in.rdy    = (state != FULL);
    assign msg_out.valid = (state != EMPTY);

    assign in_accept  = msg_in.valid && (state != FULL);
    assign out_accept = (state != EMPTY) && msg_out.rdy;

    assign msg_out.data  = main_q.data;
    assign msg_out.sop   = main_q.sop;
    assign msg_out.eop   = main_q.eop;
    assign msg_out.empty = main_q.empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_accept) begin
                        main_q <= in_beat;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_accept && out_accept) begin
                        main_q <= in_beat;
                    end else if (in_accept) begin
                        // Consumer stalled in the same cycle rdy was already promised.
                        skid_q <= in_beat;
                        state  <= FULL;
                    end else if (out_accept) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // rdy is low here, so only the drain side can move.
                    if (out_accept) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count <= '0;
        end else if (clear_stats) begin
            pkt_count <= '0;
        end else if (out_accept && main_q.eop && (pkt_count != {COUNT_WIDTH{1'b1}})) begin
            pkt_count <= pkt_count + 1'b1;
        end
    end

    avalon_st_protocol_checker u_checker (
        .clk          (clk),
        .rst          (rst),
        .beat_accept  (in_accept),
        .sop          (msg_in.sop),
        .eop          (msg_in.eop),
        .clear_stats  (clear_stats),
        .protocol_err (protocol_err)
    );

endmodule
